// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-mode constants and a
// helper that returns the length of one frame in clock cycles.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Clocks from the first start-bit cycle to the last stop-bit cycle, inclusive.
    function automatic int unsigned frame_clks(input int unsigned n_bits,
                                               input int unsigned clks_per_bit,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return clks_per_bit * (1 + n_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Reloadable bit-time down-counter shared by UART transmit and receive paths.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (counter cleared to 0)
//   load_i     reload the counter with ClksPerBit-1 on the next edge
//   bit_end_o  counter is 0: this is the last cycle of the current bit
//   pre_end_o  counter is 1: the next cycle is the last cycle of the current bit
module uart_baud_tick #(
    parameter int unsigned ClksPerBit = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic bit_end_o,
    output logic pre_end_o
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(ClksPerBit - 1);

    if (ClksPerBit < 2) begin : gen_clks_chk
        $fatal(1, "uart_baud_tick: ClksPerBit must be at least 2");
    end

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Reload;
        end else if (cnt_q != '0) begin
            // Holds at zero while nothing reloads it (transmitter idle).
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == '0);
    assign pre_end_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter fed directly by a zero-latency FIFO. Pops a word whenever the FIFO
// has data and the line is free, then sends start, data LSB-first, optional parity and
// stop bit(s). A new word popped on the last stop cycle starts without an idle gap.
// Ports:
//   clk             clock
//   reset_n         asynchronous active-low reset
//   tx_enable       permits new pops; a frame in progress always completes
//   fifo_not_empty  upstream FIFO has a word
//   data_in         upstream FIFO head word
//   shift_out       pop strobe; data_in is captured in the same cycle
//   txd             serial line, idles high
//   busy            frame in progress (cycle after pop through last stop cycle)
//   tx_done         one-cycle pulse on the last stop-bit cycle
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int unsigned bits         = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tx_enable,
    input  logic            fifo_not_empty,
    input  logic [bits-1:0] data_in,
    output logic            shift_out,
    output logic            txd,
    output logic            busy,
    output logic            tx_done
);

    if (bits < 5 || bits > 9) begin : gen_bits_chk
        $fatal(1, "uart_tx_fifo_drain: bits must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : gen_clks_chk
        $fatal(1, "uart_tx_fifo_drain: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY > PAR_ODD) begin : gen_parity_chk
        $fatal(1, "uart_tx_fifo_drain: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_stop_chk
        $fatal(1, "uart_tx_fifo_drain: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned IdxW = $clog2(bits);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(bits - 1);

    tx_state_t       state_q, state_d;
    logic [bits-1:0] sreg_q, sreg_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            par_q, par_d;
    logic            stop_idx_q, stop_idx_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load;
    logic            bit_end;
    logic            pre_end;
    logic            stop_last;
    logic            final_stop;

    uart_baud_tick #(
        .ClksPerBit (CLKS_PER_BIT)
    ) u_baud (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (load),
        .bit_end_o  (bit_end),
        .pre_end_o  (pre_end)
    );

    assign stop_last  = (STOP_BITS == 1) || stop_idx_q;
    assign final_stop = (state_q == STOP) && bit_end && stop_last;

    // Gated by reset_n so no pop can be issued while the block is held in reset.
    assign shift_out = reset_n && tx_enable && fifo_not_empty &&
                       ((state_q == IDLE) || final_stop);

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        par_d      = par_q;
        stop_idx_d = stop_idx_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (shift_out) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sreg_d = sreg_q >> 1;
                    load   = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d    = (PARITY != PAR_NONE) ? PAR : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    load       = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        state_d = IDLE;
                        if (shift_out) begin
                            state_d = START;
                            load    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        load       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (shift_out) begin
            sreg_d = data_in;
            par_d  = (^data_in) ^ (PARITY == PAR_ODD);
        end
    end

    // Line level and status are computed from next state so the outputs can be registered.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = sreg_d[0];
            PAR:     txd_d = par_d;
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        // Counter at 1 means the following cycle is the final cycle of this stop bit.
        done_d = (state_q == STOP) && stop_last && pre_end;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            idx_q      <= '0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            par_q      <= par_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: four transmitter instances (8N1, 8E1, 8O1, 8N2, 4 clks/bit) share one
// FIFO model; only the selected instance sees fifo_not_empty.
module tb_uart_tx_fifo_drain;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_enable;
    logic [1:0] sel;
    logic [7:0] fifo_mem [8];
    logic [2:0] head = 3'd0;
    logic [2:0] tail = 3'd0;
    logic [7:0] din;
    logic [3:0] ne_w, pop_w, txd_w, busy_w, done_w;
    logic       pop_s, txd_s, busy_s, done_s;

    logic line_v [0:199];
    logic done_v [0:199];
    logic busy_v [0:199];
    int   n_pops;
    int   pop_at [4];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    assign din    = fifo_mem[head];
    assign ne_w   = (tail != head) ? (4'b0001 << sel) : 4'b0000;
    assign pop_s  = pop_w[sel];
    assign txd_s  = txd_w[sel];
    assign busy_s = busy_w[sel];
    assign done_s = done_w[sel];

    always @(posedge clk) begin
        if (pop_s && (tail != head)) head <= head + 3'd1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_fifo_drain #(
            .bits         (8),
            .CLKS_PER_BIT (4),
            .PARITY       ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .tx_enable      (tx_enable),
            .fifo_not_empty (ne_w[g]),
            .data_in        (din),
            .shift_out      (pop_w[g]),
            .txd            (txd_w[g]),
            .busy           (busy_w[g]),
            .tx_done        (done_w[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fifo_mem[tail] = d;
        tail = tail + 3'd1;
    endtask

    task automatic wait_pop(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pop_s) found = 1'b1;
            else @(negedge clk);
        end
        check_eq({tag, "_pop"}, 32'(found), 32'd1);
    endtask

    // Record n clocks after the pop cycle; clock k is sampled on the k-th falling edge.
    task automatic capture(input int n, input int drop_clk);
        n_pops = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            line_v[k] = txd_s;
            done_v[k] = done_s;
            busy_v[k] = busy_s;
            if (pop_s) begin
                if (n_pops < 4) pop_at[n_pops] = k;
                n_pops++;
            end
            if (k == drop_clk) tx_enable = 1'b0;
        end
    endtask

    function automatic int count_hi(input int which, input int lo, input int hi);
        int c;
        c = 0;
        for (int k = lo; k <= hi; k++) begin
            if (which == 0 && line_v[k] === 1'b1) c++;
            if (which == 1 && done_v[k] === 1'b1) c++;
            if (which == 2 && busy_v[k] === 1'b1) c++;
        end
        return c;
    endfunction

    // Decode nbits line bits of 4 clocks each after clock 'start'; bit i of exp is the
    // i-th bit on the line (start bit first).
    task automatic check_frame(input string tag, input int start, input int nbits,
                               input logic [31:0] exp);
        logic [31:0] obs;
        int          glitch;
        obs    = '0;
        glitch = 0;
        for (int b = 0; b < nbits; b++) begin
            obs[b] = line_v[start + b * 4 + 1];
            for (int c = 2; c <= 4; c++) begin
                if (line_v[start + b * 4 + c] !== obs[b]) glitch++;
            end
        end
        check_eq(tag, obs, exp);
        check_eq({tag, "_stable"}, 32'(glitch), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        tx_enable = 1'b1;
        sel       = 2'd0;
        repeat (2) @(negedge clk);

        // Reset state, with a word already waiting.
        push(8'hA5);
        #1;
        check_eq("rst_txd", 32'(txd_s), 32'd1);
        check_eq("rst_busy", 32'(busy_s), 32'd0);
        check_eq("rst_done", 32'(done_s), 32'd0);
        check_eq("rst_shift_out", 32'(pop_s), 32'd0);

        // 8N1, 0xA5.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        wait_pop("a5");
        capture(44, -1);
        check_frame("a5_frame", 0, 10, 32'h34A);
        check_eq("a5_done_at40", 32'(done_v[40]), 32'd1);
        check_eq("a5_done_count", 32'(count_hi(1, 1, 44)), 32'd1);
        check_eq("a5_busy_first", 32'(busy_v[1]), 32'd1);
        check_eq("a5_busy_last", 32'(busy_v[40]), 32'd1);
        check_eq("a5_busy_after", 32'(busy_v[41]), 32'd0);
        check_eq("a5_extra_pops", 32'(n_pops), 32'd0);
        check_eq("a5_idle_high", 32'(count_hi(0, 41, 44)), 32'd4);

        // Three back-to-back frames.
        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        #1;
        wait_pop("b2b");
        capture(124, -1);
        check_frame("b2b_f0", 0, 10, 32'h200);
        check_frame("b2b_f1", 40, 10, 32'h3FE);
        check_frame("b2b_f2", 80, 10, 32'h278);
        check_eq("b2b_pops", 32'(n_pops), 32'd2);
        check_eq("b2b_pop1_at", 32'(pop_at[0]), 32'd40);
        check_eq("b2b_pop2_at", 32'(pop_at[1]), 32'd80);
        check_eq("b2b_done_count", 32'(count_hi(1, 1, 124)), 32'd3);
        check_eq("b2b_done_pos", 32'({done_v[40], done_v[80], done_v[120]}), 32'h7);
        check_eq("b2b_busy_span", 32'(count_hi(2, 1, 120)), 32'd120);
        check_eq("b2b_busy_after", 32'(busy_v[121]), 32'd0);

        // Even parity, 0x07.
        @(negedge clk);
        sel = 2'd1;
        push(8'h07);
        #1;
        wait_pop("even");
        capture(48, -1);
        check_frame("even_frame", 0, 11, 32'h60E);
        check_eq("even_done_at44", 32'(done_v[44]), 32'd1);
        check_eq("even_done_count", 32'(count_hi(1, 1, 48)), 32'd1);
        check_eq("even_busy_after", 32'(busy_v[45]), 32'd0);

        // Odd parity, 0x07.
        @(negedge clk);
        sel = 2'd2;
        push(8'h07);
        #1;
        wait_pop("odd");
        capture(48, -1);
        check_frame("odd_frame", 0, 11, 32'h40E);
        check_eq("odd_done_at44", 32'(done_v[44]), 32'd1);

        // Two stop bits, 0x55.
        @(negedge clk);
        sel = 2'd3;
        push(8'h55);
        #1;
        wait_pop("stop2");
        capture(48, -1);
        check_frame("stop2_frame", 0, 11, 32'h6AA);
        check_eq("stop2_done_at40", 32'(done_v[40]), 32'd0);
        check_eq("stop2_done_at44", 32'(done_v[44]), 32'd1);
        check_eq("stop2_done_count", 32'(count_hi(1, 1, 48)), 32'd1);
        check_eq("stop2_busy_after", 32'(busy_v[45]), 32'd0);

        // tx_enable dropped at clock 10 with a second word queued.
        @(negedge clk);
        sel = 2'd0;
        push(8'h81);
        push(8'h42);
        #1;
        wait_pop("en");
        capture(60, 10);
        check_frame("en_frame", 0, 10, 32'h302);
        check_eq("en_no_pop", 32'(n_pops), 32'd0);
        check_eq("en_done_at40", 32'(done_v[40]), 32'd1);
        check_eq("en_idle_high", 32'(count_hi(0, 41, 60)), 32'd20);
        check_eq("en_busy_after", 32'(busy_v[41]), 32'd0);
        tx_enable = 1'b1;
        #1;
        check_eq("en_reenable_pop", 32'(pop_s), 32'd1);
        capture(44, -1);
        check_frame("en_frame2", 0, 10, 32'h284);

        // Asynchronous reset at clock 17 (data bit 3 of 0x52 is 0).
        @(negedge clk);
        push(8'h52);
        push(8'hC3);
        #1;
        wait_pop("rst");
        capture(17, -1);
        check_eq("rst_pre_txd", 32'(line_v[17]), 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_txd", 32'(txd_s), 32'd1);
        check_eq("rst_async_busy", 32'(busy_s), 32'd0);
        check_eq("rst_async_shift_out", 32'(pop_s), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_hold_shift_out", 32'(pop_s), 32'd0);
        reset_n = 1'b1;
        #1;
        check_eq("rst_release_pop", 32'(pop_s), 32'd1);
        capture(44, -1);
        check_frame("rst_frame", 0, 10, 32'h386);
        check_eq("rst_done_at40", 32'(done_v[40]), 32'd1);
        check_eq("rst_done_count", 32'(count_hi(1, 1, 44)), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
